// File: rtl/serial_add_sub.sv
// Slice-serial adder/subtractor: SLICE bits per clock through a ripple of full
// adders, with a registered carry between slices; strt/done handshake.
//
// state | meaning
// IDLE  | waiting for strt; result and flags hold the last completed value
// BUSY  | slices in progress, one per clock, LSB slice first
module serial_add_sub #(
  parameter int WIDTH = 16,
  parameter int SLICE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             strt,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] result,
  output logic             Cout,
  output logic             OV,
  output logic             Z,
  output logic             busy,
  output logic             done
);

  localparam int N  = WIDTH / SLICE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  localparam logic IDLE = 1'b0;
  localparam logic BUSY = 1'b1;

  logic             state;
  logic [WIDTH-1:0] a_shft;
  logic [WIDTH-1:0] b_shft;
  logic             carry;
  logic             a_msb;
  logic             b_msb;
  logic [CW-1:0]    counter;

  logic [SLICE:0]   cc;
  logic [SLICE-1:0] s;
  logic [WIDTH-1:0] res_nxt;

  assign busy  = (state == BUSY);
  assign cc[0] = carry;

  for (genvar i = 0; i < SLICE; i++) begin : g_fa
    assign s[i]    = a_shft[i] ^ b_shft[i] ^ cc[i];
    assign cc[i+1] = (a_shft[i] & b_shft[i]) | (cc[i] & (a_shft[i] ^ b_shft[i]));
  end

  // With a single slice the whole result is produced in one step.
  if (SLICE == WIDTH) begin : g_one
    assign res_nxt = s;
  end else begin : g_multi
    assign res_nxt = {s, result[WIDTH-1:SLICE]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_shft  <= '0;
      b_shft  <= '0;
      carry   <= 1'b0;
      a_msb   <= 1'b0;
      b_msb   <= 1'b0;
      counter <= '0;
      result  <= '0;
      Cout    <= 1'b0;
      OV      <= 1'b0;
      Z       <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (strt) begin
            a_shft  <= A;
            b_shft  <= sub ? ~B : B;
            carry   <= sub;
            a_msb   <= A[WIDTH-1];
            b_msb   <= sub ? ~B[WIDTH-1] : B[WIDTH-1];
            counter <= '0;
            result  <= '0;
            Cout    <= 1'b0;
            OV      <= 1'b0;
            Z       <= 1'b0;
            state   <= BUSY;
          end
        end
        default: begin
          result  <= res_nxt;
          a_shft  <= a_shft >> SLICE;
          b_shft  <= b_shft >> SLICE;
          carry   <= cc[SLICE];
          counter <= counter + 1'b1;
          if (counter == LAST) begin
            state <= IDLE;
            done  <= 1'b1;
            Cout  <= cc[SLICE];
            OV    <= (a_msb == b_msb) && (s[SLICE-1] != a_msb);
            Z     <= (res_nxt == '0);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_sub.sv
// Bench for serial_add_sub: three configurations (16/1, 16/4, 8/8) share operands
// and are checked against an arithmetic reference model.
module tb_serial_add_sub;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        strt1 = 1'b0, strt4 = 1'b0, strt8 = 1'b0;
  logic        sub = 1'b0;
  logic [15:0] a_in = '0, b_in = '0;

  logic [15:0] res1, res4;
  logic [7:0]  res8;
  logic        co1, ov1, z1, busy1, done1;
  logic        co4, ov4, z4, busy4, done4;
  logic        co8, ov8, z8, busy8, done8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_add_sub #(.WIDTH(16), .SLICE(1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .strt(strt1), .sub(sub), .A(a_in), .B(b_in),
    .result(res1), .Cout(co1), .OV(ov1), .Z(z1), .busy(busy1), .done(done1));

  serial_add_sub #(.WIDTH(16), .SLICE(4)) u_s4 (
    .clk(clk), .rst_n(rst_n), .strt(strt4), .sub(sub), .A(a_in), .B(b_in),
    .result(res4), .Cout(co4), .OV(ov4), .Z(z4), .busy(busy4), .done(done4));

  serial_add_sub #(.WIDTH(8), .SLICE(8)) u_s8 (
    .clk(clk), .rst_n(rst_n), .strt(strt8), .sub(sub), .A(a_in[7:0]), .B(b_in[7:0]),
    .result(res8), .Cout(co8), .OV(ov8), .Z(z8), .busy(busy8), .done(done8));

  // Reference: plain integer arithmetic. Returns {cout, ov, z, result[15:0]}.
  function automatic logic [18:0] model(input int w, input logic [15:0] a,
                                        input logic [15:0] b, input logic s);
    longint mask, ua, ub, sum, sa, sb, r, half, res;
    logic c, o, zz;
    mask = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    ua   = longint'(a) & mask;
    ub   = longint'(b) & mask;
    sum  = s ? (ua + ((~ub) & mask) + 1) : (ua + ub);
    res  = sum & mask;
    c    = ((sum >> w) & 1) != 0;
    sa   = (ua >= half) ? ua - 2 * half : ua;
    sb   = (ub >= half) ? ub - 2 * half : ub;
    r    = s ? (sa - sb) : (sa + sb);
    o    = (r >= half) || (r < -half);
    zz   = (res == 0);
    return {c, o, zz, res[15:0]};
  endfunction

  task automatic test_reset();
    #1;
    checks++;
    if ({res1, co1, ov1, z1, busy1, done1} !== 21'd0) begin
      errors++; $display("FAIL reset_s1 got %h want 0", {res1, co1, ov1, z1, busy1, done1});
    end
    checks++;
    if ({res4, co4, ov4, z4, busy4, done4} !== 21'd0) begin
      errors++; $display("FAIL reset_s4 got %h want 0", {res4, co4, ov4, z4, busy4, done4});
    end
    checks++;
    if ({res8, co8, ov8, z8, busy8, done8} !== 13'd0) begin
      errors++; $display("FAIL reset_s8 got %h want 0", {res8, co8, ov8, z8, busy8, done8});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One operation on all three configurations; checks latency, pulse width, result, flags.
  task automatic test_vec(input logic [15:0] a, input logic [15:0] b, input logic s);
    int          lat[3];
    int          pulses[3];
    logic [18:0] got[3];
    logic [18:0] exp;
    int          wid[3];
    int          nn[3];
    wid = '{16, 16, 8};
    nn  = '{16, 4, 1};
    for (int k = 0; k < 3; k++) begin lat[k] = -1; pulses[k] = 0; got[k] = '0; end
    @(negedge clk);
    a_in = a; b_in = b; sub = s;
    strt1 = 1'b1; strt4 = 1'b1; strt8 = 1'b1;
    @(negedge clk);
    strt1 = 1'b0; strt4 = 1'b0; strt8 = 1'b0;
    checks++;
    if (busy1 !== 1'b1) begin errors++; $display("FAIL busy_after_start got %b want 1", busy1); end
    for (int c = 1; c <= 24; c++) begin
      @(negedge clk);
      if (done1) begin pulses[0]++; if (lat[0] < 0) begin lat[0] = c; got[0] = {co1, ov1, z1, res1}; end end
      if (done4) begin pulses[1]++; if (lat[1] < 0) begin lat[1] = c; got[1] = {co4, ov4, z4, res4}; end end
      if (done8) begin pulses[2]++; if (lat[2] < 0) begin lat[2] = c; got[2] = {co8, ov8, z8, 8'h00, res8}; end end
    end
    for (int k = 0; k < 3; k++) begin
      exp = model(wid[k], a, b, s);
      checks++;
      if (lat[k] != nn[k]) begin
        errors++; $display("FAIL latency inst%0d a=%h b=%h sub=%b got %0d want %0d", k, a, b, s, lat[k], nn[k]);
      end
      checks++;
      if (pulses[k] != 1) begin
        errors++; $display("FAIL done_pulses inst%0d got %0d want 1", k, pulses[k]);
      end
      checks++;
      if (got[k] !== exp) begin
        errors++; $display("FAIL result inst%0d a=%h b=%h sub=%b got {c,ov,z,r}=%h want %h", k, a, b, s, got[k], exp);
      end
    end
  endtask

  task automatic test_directed();
    test_vec(16'h1234, 16'h4321, 1'b0);
    test_vec(16'h7FFF, 16'h0001, 1'b0);
    test_vec(16'hFFFF, 16'h0001, 1'b0);
    test_vec(16'h0005, 16'h0007, 1'b1);
    test_vec(16'h8000, 16'h0001, 1'b1);
    test_vec(16'h1234, 16'h1234, 1'b1);
    test_vec(16'h0080, 16'h0080, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 25; i++)
      test_vec(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
  endtask

  // strt while busy is ignored; strt coincident with done is accepted.
  task automatic test_busy_and_restart();
    int          lat;
    logic [18:0] got, exp;
    lat = -1; got = '0;
    @(negedge clk);
    a_in = 16'h1111; b_in = 16'h0F0F; sub = 1'b0; strt1 = 1'b1;
    @(negedge clk);
    strt1 = 1'b0;
    for (int c = 1; c <= 24; c++) begin
      @(negedge clk);
      strt1 = 1'b0;
      if (done1 && lat < 0) begin
        lat = c; got = {co1, ov1, z1, res1};
        a_in = 16'h0003; b_in = 16'h0009; sub = 1'b1; strt1 = 1'b1;
        break;
      end
      if (c == 5) begin
        checks++;
        if (busy1 !== 1'b1) begin errors++; $display("FAIL busy_mid got %b want 1", busy1); end
        a_in = 16'hAAAA; b_in = 16'h5555; sub = 1'b1; strt1 = 1'b1;
      end
    end
    exp = model(16, 16'h1111, 16'h0F0F, 1'b0);
    checks++;
    if (lat != 16) begin errors++; $display("FAIL ignore_latency got %0d want 16", lat); end
    checks++;
    if (got !== exp) begin errors++; $display("FAIL ignore_result got %h want %h", got, exp); end
    @(negedge clk);
    strt1 = 1'b0;
    checks++;
    if ({busy1, done1, res1, co1, ov1, z1} !== {2'b10, 19'd0}) begin
      errors++; $display("FAIL restart_clear got %h want %h", {busy1, done1, res1, co1, ov1, z1}, {2'b10, 19'd0});
    end
    lat = -1;
    for (int c = 1; c <= 24; c++) begin
      @(negedge clk);
      if (done1 && lat < 0) begin lat = c; got = {co1, ov1, z1, res1}; end
    end
    exp = model(16, 16'h0003, 16'h0009, 1'b1);
    checks++;
    if (lat != 16) begin errors++; $display("FAIL restart_latency got %0d want 16", lat); end
    checks++;
    if (got !== exp) begin errors++; $display("FAIL restart_result got %h want %h", got, exp); end
  endtask

  // strt held high on the SLICE=4 instance: a new operation every N+1 = 5 cycles.
  task automatic test_back_to_back();
    int          times[$];
    logic [18:0] exp;
    exp = model(16, 16'h0F00, 16'h00F0, 1'b0);
    @(negedge clk);
    a_in = 16'h0F00; b_in = 16'h00F0; sub = 1'b0; strt4 = 1'b1;
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      if (done4) begin
        times.push_back(c);
        checks++;
        if ({co4, ov4, z4, res4} !== exp) begin
          errors++; $display("FAIL b2b_result got %h want %h", {co4, ov4, z4, res4}, exp);
        end
      end
    end
    strt4 = 1'b0;
    checks++;
    if (times.size() != 3) begin
      errors++; $display("FAIL b2b_count got %0d want 3", times.size());
    end else begin
      checks++;
      if (times[1] - times[0] != 5 || times[2] - times[1] != 5) begin
        errors++; $display("FAIL b2b_interval got %0d,%0d want 5,5", times[1] - times[0], times[2] - times[1]);
      end
    end
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int pulses;
    pulses = 0;
    @(negedge clk);
    a_in = 16'hFFFF; b_in = 16'hFFFF; sub = 1'b0; strt1 = 1'b1;
    @(negedge clk);
    strt1 = 1'b0;
    repeat (8) @(negedge clk);
    checks++;
    if (res1 === 16'h0000) begin errors++; $display("FAIL partial_nonzero got %h want nonzero", res1); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy1, done1, res1, co1, ov1, z1} !== 21'd0) begin
      errors++; $display("FAIL reset_mid got %h want 0", {busy1, done1, res1, co1, ov1, z1});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      if (done1) pulses++;
    end
    checks++;
    if (pulses != 0 || busy1 !== 1'b0) begin
      errors++; $display("FAIL no_done_after_reset got pulses=%0d busy=%b want 0,0", pulses, busy1);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_busy_and_restart();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
